// File: rtl/ste_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ste_pkg
// Purpose  : Shared definitions for the STE chain matcher: the bit positions
//            of the per-STE configuration flags and a packed view of them.
// Revision : 1.0 - initial release
// ============================================================================
package ste_pkg;

    // Bit positions inside the 4-bit cfg_flags word {enable, start, self_loop, report}
    localparam int CFG_ENABLE    = 3;
    localparam int CFG_START     = 2;
    localparam int CFG_SELF_LOOP = 1;
    localparam int CFG_REPORT    = 0;
    localparam int CFG_FLAGS_W   = 4;

    typedef struct packed {
        logic enable;
        logic start;
        logic self_loop;
        logic report;
    } ste_flags_t;

    // Decode by named bit position so the struct layout never has to track
    // the port encoding.
    function automatic ste_flags_t unpack_flags(input logic [CFG_FLAGS_W-1:0] flags);
        ste_flags_t f;
        f.enable    = flags[CFG_ENABLE];
        f.start     = flags[CFG_START];
        f.self_loop = flags[CFG_SELF_LOOP];
        f.report    = flags[CFG_REPORT];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ste_cell.sv
`default_nettype none
// ============================================================================
// Module   : ste_cell
// Purpose  : One state-transition element: configuration register, masked
//            symbol compare, activation flop and fire output.
// Ports    : clock/reset      - clock, synchronous active-high reset
//            i_cfg_we         - write this cell's configuration (addr decoded)
//            i_cfg_match/mask - match value / compare mask (1 = compare)
//            i_cfg_flags      - {enable, start, self_loop, report}
//            i_accept/i_last  - a symbol is accepted this cycle / it ends the stream
//            i_symbol         - symbol under test
//            i_start_ok       - start STEs may be entered on this symbol
//            i_prev_fire      - fire of the preceding cell (0 for cell 0)
//            o_fire           - this cell fires on i_symbol
//            o_report         - report flag of this cell
// Revision : 1.0 - initial release
// ============================================================================
module ste_cell
    import ste_pkg::*;
#(
    parameter int SYMBOL_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_cfg_we,
    input  logic [SYMBOL_WIDTH-1:0] i_cfg_match,
    input  logic [SYMBOL_WIDTH-1:0] i_cfg_mask,
    input  logic [CFG_FLAGS_W-1:0]  i_cfg_flags,
    input  logic                    i_accept,
    input  logic                    i_last,
    input  logic [SYMBOL_WIDTH-1:0] i_symbol,
    input  logic                    i_start_ok,
    input  logic                    i_prev_fire,
    output logic                    o_fire,
    output logic                    o_report
);

    typedef struct packed {
        logic [SYMBOL_WIDTH-1:0] match;
        logic [SYMBOL_WIDTH-1:0] mask;
        ste_flags_t              flags;
    } ste_cfg_t;

    ste_cfg_t r_cfg_q;
    ste_cfg_t w_cfg_d;
    logic     r_act_q;
    logic     w_act_d;
    logic     w_match;
    logic     w_en;

    always_comb begin
        w_cfg_d = r_cfg_q;
        if (i_cfg_we) begin
            w_cfg_d.match = i_cfg_match;
            w_cfg_d.mask  = i_cfg_mask;
            w_cfg_d.flags = unpack_flags(i_cfg_flags);
        end

        // Compare uses the registered config, so a write in the same cycle as
        // an accept only affects later symbols.
        w_match = r_cfg_q.flags.enable &&
                  (((i_symbol ^ r_cfg_q.match) & r_cfg_q.mask) == '0);
        w_en    = r_act_q || (r_cfg_q.flags.start && i_start_ok);
        o_fire  = w_en && w_match;

        w_act_d = r_act_q;
        if (i_accept) begin
            // End of stream wipes activation after the last symbol is scored.
            w_act_d = i_last ? 1'b0 : (i_prev_fire || (r_cfg_q.flags.self_loop && o_fire));
        end
    end

    assign o_report = r_cfg_q.flags.report;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cfg_q <= '0;
            r_act_q <= 1'b0;
        end else begin
            r_cfg_q <= w_cfg_d;
            r_act_q <= w_act_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ste_chain_matcher.sv
`default_nettype none
// ============================================================================
// Module   : ste_chain_matcher
// Purpose  : Linear chain of NUM_STES runtime-programmable STEs scanning a
//            valid/ready symbol stream; emits one registered report per
//            symbol on which any reporting STE fires.
// Ports    : clock/reset             - clock, synchronous active-high reset
//            cfg_we/addr/match/mask/flags - per-STE configuration write
//            mode_sod                - 1: start STEs only on first symbol of stream
//            in_valid/in_ready/in_symbol/in_last - symbol stream
//            report_valid/report_ready - report handshake
//            report_ste_mask         - reporting STEs that fired
//            report_offset           - 0-based stream offset of the firing symbol
// Revision : 1.0 - initial release
// ============================================================================
module ste_chain_matcher
    import ste_pkg::*;
#(
    parameter int SYMBOL_WIDTH = 16,
    parameter int NUM_STES     = 8,
    parameter int OFFSET_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_STES)-1:0] cfg_addr,
    input  logic [SYMBOL_WIDTH-1:0]     cfg_match,
    input  logic [SYMBOL_WIDTH-1:0]     cfg_mask,
    input  logic [CFG_FLAGS_W-1:0]      cfg_flags,
    input  logic                        mode_sod,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SYMBOL_WIDTH-1:0]     in_symbol,
    input  logic                        in_last,
    output logic                        report_valid,
    input  logic                        report_ready,
    output logic [NUM_STES-1:0]         report_ste_mask,
    output logic [OFFSET_WIDTH-1:0]     report_offset
);

    localparam int ADDR_W = $clog2(NUM_STES);

    logic                    w_accept;
    logic                    w_start_ok;
    logic [NUM_STES-1:0]     w_fire;
    logic [NUM_STES-1:0]     w_report_flag;
    logic [NUM_STES-1:0]     w_prev_fire;
    logic [NUM_STES-1:0]     w_hit;

    logic [OFFSET_WIDTH-1:0] r_offset_q,        w_offset_d;
    logic                    r_sod_first_q,     w_sod_first_d;
    logic                    r_report_valid_q,  w_report_valid_d;
    logic [NUM_STES-1:0]     r_report_mask_q,   w_report_mask_d;
    logic [OFFSET_WIDTH-1:0] r_report_offset_q, w_report_offset_d;

    // Only a held, unconsumed report stalls the stream.
    assign in_ready    = !r_report_valid_q || report_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_start_ok  = !mode_sod || r_sod_first_q;
    // Cell 0 has no predecessor; the last cell's fire feeds nothing onward.
    assign w_prev_fire = {w_fire[NUM_STES-2:0], 1'b0};

    generate
        for (genvar i = 0; i < NUM_STES; i++) begin : g_ste
            // Addresses beyond the chain length decode to no cell.
            localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(i);

            ste_cell #(
                .SYMBOL_WIDTH (SYMBOL_WIDTH)
            ) u_cell (
                .clock       (clock),
                .reset       (reset),
                .i_cfg_we    (cfg_we && (cfg_addr == c_idx)),
                .i_cfg_match (cfg_match),
                .i_cfg_mask  (cfg_mask),
                .i_cfg_flags (cfg_flags),
                .i_accept    (w_accept),
                .i_last      (in_last),
                .i_symbol    (in_symbol),
                .i_start_ok  (w_start_ok),
                .i_prev_fire (w_prev_fire[i]),
                .o_fire      (w_fire[i]),
                .o_report    (w_report_flag[i])
            );
        end
    endgenerate

    assign w_hit = w_fire & w_report_flag;

    always_comb begin
        w_offset_d        = r_offset_q;
        w_sod_first_d     = r_sod_first_q;
        w_report_valid_d  = r_report_valid_q;
        w_report_mask_d   = r_report_mask_q;
        w_report_offset_d = r_report_offset_q;

        if (w_accept) begin
            if (in_last) begin
                w_offset_d    = '0;
                w_sod_first_d = 1'b1;
            end else begin
                w_offset_d    = r_offset_q + OFFSET_WIDTH'(1);
                w_sod_first_d = 1'b0;
            end
        end

        if (r_report_valid_q && report_ready) begin
            w_report_valid_d = 1'b0;
        end
        // A new report overrides the consume above, so valid stays high
        // across back-to-back reports.
        if (w_accept && (|w_hit)) begin
            w_report_valid_d  = 1'b1;
            w_report_mask_d   = w_hit;
            w_report_offset_d = r_offset_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_offset_q        <= '0;
            r_sod_first_q     <= 1'b1;
            r_report_valid_q  <= 1'b0;
            r_report_mask_q   <= '0;
            r_report_offset_q <= '0;
        end else begin
            r_offset_q        <= w_offset_d;
            r_sod_first_q     <= w_sod_first_d;
            r_report_valid_q  <= w_report_valid_d;
            r_report_mask_q   <= w_report_mask_d;
            r_report_offset_q <= w_report_offset_d;
        end
    end

    assign report_valid    = r_report_valid_q;
    assign report_ste_mask = r_report_mask_q;
    assign report_offset   = r_report_offset_q;

endmodule
`default_nettype wire
